// File: rtl/regfile_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_arbiter_pkg
// Description : Shared widths, the hard-wired zero register index and the
//               buffered write-back entry type for the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_writeback_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Register 0 is hard-wired; writes to it are discarded.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // One pending register-file write.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : DEPTH-entry circular buffer of pending write-back entries.
//               No fall-through: an entry pushed this cycle becomes the head
//               only after the edge. Exposes per-entry valid/rd so that the
//               decode scoreboard can search every buffered destination.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  wb_entry_t                         push_entry,
    input  logic                              pop,
    output wb_entry_t                         head,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic [DEPTH-1:0]                  ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]      ent_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = mem[rd_ptr];

    // An entry is live when its distance from the read pointer is below count.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset       = PTR_W'(i) - rd_ptr;
            assign ent_valid[i] = ({1'b0, offset} < count);
            assign ent_rd[i]    = mem[i].rd;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_arbiter
// Description : Write-back stage feeding the 32x32 register file. Merges the
//               non-stallable ALU/load result with buffered multiply/divide
//               results (ALU has priority), provides pending-write lookups for
//               decode and raises a one-cycle stall request when the buffered
//               results have been deferred STARVE_MAX cycles in a row.
//               Optional feature macro: WB_BYPASS_EN (adds forwarding ports
//               and restricts pend_busyN to buffered entries).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_arbiter #(
    parameter int DATA_W     = regfile_writeback_arbiter_pkg::DATA_W,
    parameter int ADDR_W     = regfile_writeback_arbiter_pkg::ADDR_W,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0] md_data,
    input  logic [ADDR_W-1:0] chk_rd1,
    input  logic [ADDR_W-1:0] chk_rd2,
    output logic              pend_busy1,
    output logic              pend_busy2,
    output logic              stall_req,
`ifdef WB_BYPASS_EN
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data2,
`endif
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData
);

    import regfile_writeback_arbiter_pkg::*;

    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]             count;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
    wb_entry_t                    head;
    wb_entry_t                    push_entry;

    logic                alu_take;
    logic                fifo_nonempty;
    logic                fifo_pop;
    logic                md_push;
    logic                alu_defers_fifo;
    logic [STARVE_W-1:0] starve_cnt;
    logic                fifo_hit1;
    logic                fifo_hit2;
    logic                out_hit1;
    logic                out_hit2;

    // Handshake depends on occupancy only; held low while in reset.
    assign md_ready = !reset && (count < CNT_W'(DEPTH));

    assign alu_take        = alu_valid && (alu_rd != REG_ZERO);
    assign fifo_nonempty   = (count != '0);
    // Head is popped only when the ALU does not claim the write port.
    assign fifo_pop        = fifo_nonempty && !alu_take;
    // Writes to r0 are acknowledged but dropped.
    assign md_push         = md_valid && md_ready && (md_rd != REG_ZERO);
    assign alu_defers_fifo = fifo_nonempty && alu_take;

    assign push_entry = '{rd: md_rd, data: md_data};

    wb_fifo #(
        .DEPTH      (DEPTH)
    ) u_wb_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (md_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .count      (count),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd)
    );

    // Output register: ALU result first, else FIFO head, else idle (hold index/data).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (alu_take) begin
            RegWrite      <= 1'b1;
            WriteRegister <= alu_rd;
            WriteData     <= alu_data;
        end else if (fifo_pop) begin
            RegWrite      <= 1'b1;
            WriteRegister <= head.rd;
            WriteData     <= head.data;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

    // Count consecutive cycles the FIFO loses to the ALU; pulse stall_req on the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else if (alu_defers_fifo) begin
            if (starve_cnt == STARVE_W'(STARVE_MAX - 1)) begin
                starve_cnt <= '0;
                stall_req  <= 1'b1;
            end else begin
                starve_cnt <= starve_cnt + 1'b1;
                stall_req  <= 1'b0;
            end
        end else begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end
    end

    // Search every live FIFO entry for the decode source registers.
    always_comb begin
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == chk_rd1)) begin
                fifo_hit1 = 1'b1;
            end
            if (ent_valid[i] && (ent_rd[i] == chk_rd2)) begin
                fifo_hit2 = 1'b1;
            end
        end
    end

    assign out_hit1 = RegWrite && (WriteRegister == chk_rd1);
    assign out_hit2 = RegWrite && (WriteRegister == chk_rd2);

`ifdef WB_BYPASS_EN
    // The committing write is forwarded, so only buffered entries stall decode.
    assign pend_busy1 = !reset && (chk_rd1 != REG_ZERO) && fifo_hit1;
    assign pend_busy2 = !reset && (chk_rd2 != REG_ZERO) && fifo_hit2;
    assign fwd_hit1   = (chk_rd1 != REG_ZERO) && out_hit1;
    assign fwd_hit2   = (chk_rd2 != REG_ZERO) && out_hit2;
    assign fwd_data1  = WriteData;
    assign fwd_data2  = WriteData;
`else
    assign pend_busy1 = !reset && (chk_rd1 != REG_ZERO) && (fifo_hit1 || out_hit1);
    assign pend_busy2 = !reset && (chk_rd2 != REG_ZERO) && (fifo_hit2 || out_hit2);
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback_arbiter
// Description : Self-checking bench for regfile_writeback_arbiter. A queue
//               based reference model predicts the register-file write port,
//               stall requests, handshake and scoreboard outputs.
//               Honours macro WB_BYPASS_EN for the forwarding ports.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_writeback_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_rd;
    logic [DATA_W-1:0] md_data;
    logic [ADDR_W-1:0] chk_rd1;
    logic [ADDR_W-1:0] chk_rd2;
    logic              pend_busy1;
    logic              pend_busy2;
    logic              stall_req;
`ifdef WB_BYPASS_EN
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;
`endif
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;

    regfile_writeback_arbiter #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .DEPTH         (DEPTH),
        .STARVE_MAX    (STARVE_MAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .md_valid      (md_valid),
        .md_ready      (md_ready),
        .md_rd         (md_rd),
        .md_data       (md_data),
        .chk_rd1       (chk_rd1),
        .chk_rd2       (chk_rd2),
        .pend_busy1    (pend_busy1),
        .pend_busy2    (pend_busy2),
        .stall_req     (stall_req),
`ifdef WB_BYPASS_EN
        .fwd_hit1      (fwd_hit1),
        .fwd_data1     (fwd_data1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data2     (fwd_data2),
`endif
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              q[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_wr;
    logic [DATA_W-1:0] m_wd;
    int                m_starve;
    logic              m_stall;
    bit                last_fire;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit m_busy(input logic [ADDR_W-1:0] r);
        if (r == '0) return 1'b0;
        foreach (q[i]) if (q[i].rd == r) return 1'b1;
        if (!BYPASS && m_we && m_wr == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_we     = 1'b0;
        m_wr     = '0;
        m_wd     = '0;
        m_starve = 0;
        m_stall  = 1'b0;
    endtask

    // Apply the current inputs to the model as one rising edge.
    task automatic model_edge();
        bit   ready;
        bit   nonempty;
        bit   alu_take;
        bit   popped;
        ent_t e;
        ready    = (q.size() < DEPTH);
        nonempty = (q.size() > 0);
        alu_take = alu_valid && (alu_rd != '0);
        popped   = 1'b0;
        if (alu_take) begin
            m_we = 1'b1; m_wr = alu_rd; m_wd = alu_data;
        end else if (nonempty) begin
            e = q.pop_front();
            m_we = 1'b1; m_wr = e.rd; m_wd = e.data;
            popped = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (nonempty && !popped) begin
            if (m_starve == STARVE_MAX - 1) begin
                m_starve = 0; m_stall = 1'b1;
            end else begin
                m_starve++; m_stall = 1'b0;
            end
        end else begin
            m_starve = 0; m_stall = 1'b0;
        end
        last_fire = md_valid && ready;
        if (last_fire && md_rd != '0) begin
            e.rd = md_rd; e.data = md_data;
            q.push_back(e);
        end
    endtask

    // One clock: combinational checks at the falling edge, registered ones after the rise.
    task automatic step();
        @(negedge clk);
        check("md_ready", md_ready, (q.size() < DEPTH));
        check("pend_busy1", pend_busy1, m_busy(chk_rd1));
        check("pend_busy2", pend_busy2, m_busy(chk_rd2));
`ifdef WB_BYPASS_EN
        check("fwd_hit1", fwd_hit1, m_we && m_wr == chk_rd1 && chk_rd1 != '0);
        check("fwd_hit2", fwd_hit2, m_we && m_wr == chk_rd2 && chk_rd2 != '0);
        check("fwd_data1", fwd_data1, m_wd);
`endif
        model_edge();
        @(posedge clk);
        #1;
        check("RegWrite", RegWrite, m_we);
        check("WriteRegister", WriteRegister, m_wr);
        check("WriteData", WriteData, m_wd);
        check("stall_req", stall_req, m_stall);
    endtask

    int  stall_cnt;
    bit  accepted;

    initial begin
        reset     = 1'b1;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        md_valid  = 1'b0;
        md_rd     = '0;
        md_data   = '0;
        chk_rd1   = 5'd5;
        chk_rd2   = '0;
        last_fire = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_RegWrite", RegWrite, 1'b0);
        check("rst_WriteRegister", WriteRegister, '0);
        check("rst_WriteData", WriteData, '0);
        check("rst_stall_req", stall_req, 1'b0);
        check("rst_md_ready", md_ready, 1'b0);
        check("rst_pend_busy1", pend_busy1, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("post_rst_md_ready", md_ready, 1'b1);

        // ALU write, then ALU write to r0
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hDEADBEEF;
        step();
        check("alu_we", RegWrite, 1'b1);
        check("alu_wr", WriteRegister, 5'd7);
        check("alu_wd", WriteData, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h11111111;
        step();
        check("alu_r0_we", RegWrite, 1'b0);
        check("alu_r0_hold_wr", WriteRegister, 5'd7);
        alu_valid = 1'b0;

        // MD write on an idle pipeline
        md_valid = 1'b1; md_rd = 5'd12; md_data = 32'h1234; chk_rd1 = 5'd12;
        step();
        check("md_busy_after_accept", pend_busy1, 1'b1);
        md_valid = 1'b0;
        step();
        check("md_we", RegWrite, 1'b1);
        check("md_wr", WriteRegister, 5'd12);
        check("md_wd", WriteData, 32'h1234);
        step();
        step();
        check("md_busy_cleared", pend_busy1, 1'b0);

        // Back-pressure and starvation with the ALU busy
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0A0A0A0;
        md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h3333; chk_rd1 = 5'd3; chk_rd2 = 5'd4;
        step();
        md_rd = 5'd4; md_data = 32'h4444;
        step();
        check("bp_md_ready_full", md_ready, 1'b0);
        md_rd = 5'd5; md_data = 32'h5555;
        stall_cnt = 0;
        accepted  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            alu_valid = !m_stall;
            alu_rd    = ADDR_W'($urandom_range(31, 6));
            alu_data  = $urandom();
            step();
            if (stall_req) stall_cnt++;
            if (md_valid && last_fire) begin
                accepted = 1'b1;
                md_valid = 1'b0;
            end
        end
        check("bp_held_md_accepted", accepted, 1'b1);
        check("starve_stall_seen", (stall_cnt != 0), 1'b1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            alu_valid = m_stall ? 1'b0 : ($urandom_range(99, 0) < 60);
            alu_rd    = ADDR_W'($urandom_range(7, 0));
            alu_data  = $urandom();
            md_valid  = $urandom_range(1, 0) == 1;
            md_rd     = ADDR_W'($urandom_range(7, 0));
            md_data   = $urandom();
            chk_rd1   = ADDR_W'($urandom_range(7, 0));
            chk_rd2   = ADDR_W'($urandom_range(7, 0));
            step();
        end

        // Reset mid-stream with two buffered entries
        md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h6666; chk_rd1 = 5'd6;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == DEPTH) break;
            alu_valid = !m_stall; alu_rd = 5'd1; alu_data = $urandom();
            step();
        end
        check("pre_rst_full", md_ready, 1'b0);
        md_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_RegWrite", RegWrite, 1'b0);
        check("mid_rst_md_ready", md_ready, 1'b0);
        check("mid_rst_pend_busy1", pend_busy1, 1'b0);
        check("mid_rst_stall_req", stall_req, 1'b0);
        @(posedge clk);
        #1;
        check("mid_rst_RegWrite_edge", RegWrite, 1'b0);
        model_reset();
        #1 reset = 1'b0; alu_valid = 1'b0;
        #1;
        check("post_mid_rst_md_ready", md_ready, 1'b1);
        repeat (4) step();

`ifdef WB_BYPASS_EN
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55; chk_rd2 = 5'd9;
        step();
        alu_valid = 1'b0;
        check("fwd_hit2_on", fwd_hit2, 1'b1);
        check("fwd_data2_val", fwd_data2, 32'h55);
        check("bypass_busy2_excl", pend_busy2, 1'b0);
        chk_rd2 = 5'd0;
        #1;
        check("fwd_hit2_r0", fwd_hit2, 1'b0);
        step();
`else
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55; chk_rd2 = 5'd9;
        step();
        alu_valid = 1'b0;
        check("out_stage_busy2", pend_busy2, 1'b1);
        chk_rd2 = 5'd0;
        #1;
        check("busy2_r0", pend_busy2, 1'b0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Write-back stage directly upstream of the 32x32 register file. It drives the file's WriteData, WriteRegister and RegWrite inputs.
- Merges two result sources into the file's single write port:
  - the in-order ALU/load pipeline result, which cannot be back-pressured;
  - a long-latency multiply/divide result, delivered over a valid/ready handshake and buffered in a small FIFO.
- Provides pending-write scoreboard lookups for the decode stage, and an anti-starvation stall request.

Parameters:
- DATA_W, 32, result and register data width
- ADDR_W, 5, register index width
- DEPTH, 2, long-latency FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive FIFO-deferred cycles before stall_req asserts

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  pipeline result present this cycle
- alu_rd  in  ADDR_W  pipeline destination register
- alu_data  in  DATA_W  pipeline result
- md_valid  in  1  long-latency result offered
- md_ready  out  1  FIFO can accept md result
- md_rd  in  ADDR_W  long-latency destination register
- md_data  in  DATA_W  long-latency result
- chk_rd1  in  ADDR_W  decode source register 1 to check
- chk_rd2  in  ADDR_W  decode source register 2 to check
- pend_busy1  out  1  chk_rd1 has a pending FIFO or output-stage write
- pend_busy2  out  1  chk_rd2 has a pending FIFO or output-stage write
- stall_req  out  1  pipeline must hold alu_valid=0 next cycle
- RegWrite  out  1  register file write enable (registered)
- WriteRegister  out  ADDR_W  register file write index (registered)
- WriteData  out  DATA_W  register file write data (registered)

Behaviour:
- Reset values: RegWrite=0, WriteRegister=0, WriteData=0, stall_req=0, FIFO empty (pointers and count = 0), starvation counter = 0. While reset is high, md_ready=0 and pend_busy1/2=0.
- Reset mid-operation discards all buffered entries; no write is issued for them.
- md handshake:
  - md_ready = (count < DEPTH), combinational from count only.
  - Transfer occurs when md_valid && md_ready at a rising edge.
  - md_rd=0 is acknowledged but not enqueued.
- ALU path:
  - alu_valid && alu_rd≠0 → next cycle RegWrite=1, WriteRegister=alu_rd, WriteData=alu_data. Latency 1.
  - alu_rd=0 → no write.
- Arbitration, evaluated each cycle:
  - The ALU path has priority.
  - If no ALU write is taken and the FIFO is non-empty, the FIFO head is popped to the output register. Latency from FIFO entry is ≥1 cycle.
  - If neither source writes, RegWrite=0 and WriteRegister/WriteData hold their previous values.
- FIFO boundaries:
  - Push and pop in the same cycle are allowed when count<DEPTH; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - A push into an empty FIFO is not poppable in the same cycle (no fall-through).
- Starvation:
  - The counter increments on each cycle where the FIFO is non-empty and the ALU wins. It clears on any FIFO pop or when the FIFO is empty.
  - When counter == STARVE_MAX-1 and the ALU wins again, stall_req=1 for exactly one cycle and the counter clears.
  - Upstream guarantees alu_valid=0 in the cycle after stall_req; the FIFO head then drains.
- Scoreboard:
  - pend_busyN = (chk_rdN≠0) && (a valid FIFO entry has rd==chk_rdN, or RegWrite && WriteRegister==chk_rdN).
  - Combinational from state.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined, adds ports:
  - fwd_hit1 out 1 and fwd_data1 out DATA_W;
  - fwd_hit2 out 1 and fwd_data2 out DATA_W.
- fwd_hitN = RegWrite && WriteRegister==chk_rdN && chk_rdN≠0, and fwd_dataN = WriteData. This lets decode bypass the write being committed this edge.
- With the feature, pend_busyN excludes the output-stage term and reports FIFO entries only.
- When undefined, the ports are absent and pend_busyN includes the output-stage term.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W constants;
  - REG_ZERO = 0;
  - a wb_entry_t typedef {rd, data}.
- One sub-module: wb_fifo, a DEPTH-entry circular buffer. It exposes push, pop, head, count and a per-entry valid/rd vector for the scoreboard.

Test Plan:
- Reset check: assert reset mid-stream with 2 FIFO entries → RegWrite=0, md_ready=0 during reset; after release md_ready=1, count=0, no stale write ever appears.
- ALU write: alu_valid=1, alu_rd=7, alu_data=0xDEADBEEF → next cycle RegWrite=1, WriteRegister=7, WriteData=0xDEADBEEF. Repeat with alu_rd=0 → RegWrite stays 0.
- MD write on an idle pipeline: md_valid with rd=12, data=0x1234 → accepted; RegWrite=1, WriteRegister=12 one cycle later. pend_busy1 with chk_rd1=12 is high from acceptance until the write is committed.
- Back-pressure: with alu_valid held high, push rd=3 and rd=4 → md_ready=0 after the second push; the third md_valid is held and not lost.
- Starvation: ALU busy every cycle with 2 FIFO entries → stall_req pulses after 4 deferred cycles. Bench drops alu_valid; rd=3 writes; the counter restarts and rd=4 follows the same sequence.
- WB_BYPASS_EN: write rd=9 data=0x55 with chk_rd2=9 → fwd_hit2=1 and fwd_data2=0x55 in the RegWrite cycle; chk_rd2=0 → fwd_hit2=0.
